// File: rtl/store_queue_pkg.sv
// Shared micro-architecture types for the store queue slice.
// Latency: n/a (types, constants and a pointer helper only).
// Backpressure: n/a.
package store_queue_pkg;

    localparam int PIPE_WIDTH    = 2;
    localparam int TAG_WIDTH     = 6;
    localparam int CPU_DATA_BITS = 32;
    localparam int STQ_DEPTH_DEF = 5;

    typedef struct packed {
        logic                     is_renamed;
        logic [TAG_WIDTH-1:0]     tag;
        logic [CPU_DATA_BITS-1:0] data;
    } src_operand_t;

    typedef struct packed {
        logic                     is_valid;
        logic [CPU_DATA_BITS-1:0] pc;
        logic [TAG_WIDTH-1:0]     dest_tag;
        logic                     agu_comp;
        src_operand_t             src_0_a;
        src_operand_t             src_1_a;
    } instruction_t;

    typedef struct packed {
        logic                     is_valid;
        logic [TAG_WIDTH-1:0]     dest_tag;
        logic [CPU_DATA_BITS-1:0] result;
    } writeback_packet_t;

    typedef struct packed {
        logic committed;
    } stq_meta_t;

    // Modulo-depth add for offsets below depth; works for non-power-of-2 depths.
    function automatic int unsigned wrap_add(int unsigned p, int unsigned n, int unsigned depth);
        int unsigned s;
        s = p + n;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/store_queue_if.sv
// Bundle of dispatch, AGU, CDB, commit, D-cache and forwarding-view signals.
// Latency: n/a (wiring only).
// Backpressure: stq_write_rdy gates allocation; cache_stall gates drain.
interface store_queue_if import store_queue_pkg::*; #(
    parameter int STQ_DEPTH = STQ_DEPTH_DEF
) ();
    logic                                   flush;
    logic                                   cache_stall;
    instruction_t                           stq_entry;
    logic                                   stq_we;
    logic                                   stq_write_rdy;
    writeback_packet_t                      agu_port;
    writeback_packet_t [PIPE_WIDTH-1:0]     cdb_ports;
    logic                                   commit_store;
    logic                                   mem_req_valid;
    logic [CPU_DATA_BITS-1:0]               mem_req_addr;
    logic [CPU_DATA_BITS-1:0]               mem_req_data;
    instruction_t [STQ_DEPTH-1:0]           store_q;
    logic                                   stq_empty;

    modport master (
        output flush, cache_stall, stq_entry, stq_we, agu_port, cdb_ports, commit_store,
        input  stq_write_rdy, mem_req_valid, mem_req_addr, mem_req_data, store_q, stq_empty
    );

    modport slave (
        input  flush, cache_stall, stq_entry, stq_we, agu_port, cdb_ports, commit_store,
        output stq_write_rdy, mem_req_valid, mem_req_addr, mem_req_data, store_q, stq_empty
    );
endinterface

// File: rtl/store_queue_cdb_match.sv
// PIPE_WIDTH-port tag comparator against the CDB; lowest-numbered port wins.
// Latency: purely combinational.
// Backpressure: none.
module stq_cdb_match import store_queue_pkg::*; (
    input  writeback_packet_t [PIPE_WIDTH-1:0] cdb_ports,
    input  logic [TAG_WIDTH-1:0]               tag,
    output logic                               hit,
    output logic [CPU_DATA_BITS-1:0]           data
);
    // Scan high to low so the lowest matching port overrides the rest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = PIPE_WIDTH - 1; k >= 0; k--) begin
            if (cdb_ports[k].is_valid && (cdb_ports[k].dest_tag == tag)) begin
                hit  = 1'b1;
                data = cdb_ports[k].result;
            end
        end
    end
endmodule

// File: rtl/store_queue.sv
// Circular store queue: in-order alloc, AGU/CDB fill, commit, drain to D-cache; optional STQ_ALLOC_SNOOP_EN.
// Latency: alloc visible next cycle; drain request combinational from head, entry freed next edge.
// Backpressure: stq_write_rdy from registered count only; cache_stall holds the head in place.
module store_queue import store_queue_pkg::*; #(
    parameter int STQ_DEPTH = STQ_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    store_queue_if.slave  sq
);
    localparam int PTR_W = (STQ_DEPTH > 1) ? $clog2(STQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(STQ_DEPTH + 1);

    instruction_t             entry_q [STQ_DEPTH];
    stq_meta_t                meta_q  [STQ_DEPTH];
    logic [PTR_W-1:0]         head_q, tail_q, cmt_ptr_q;
    logic [CNT_W-1:0]         count_q, cmt_cnt_q;

    logic                     wr_rdy, alloc, do_commit, drain;
    instruction_t             head_e, alloc_entry;
    logic                     wk_hit  [STQ_DEPTH];
    logic [CPU_DATA_BITS-1:0] wk_data [STQ_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (int'(p) == STQ_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // One comparator per entry watches the CDB for that entry's store-data tag.
    for (genvar g = 0; g < STQ_DEPTH; g++) begin : g_wake
        stq_cdb_match u_match (
            .cdb_ports (sq.cdb_ports),
            .tag       (entry_q[g].src_1_a.tag),
            .hit       (wk_hit[g]),
            .data      (wk_data[g])
        );
    end

`ifdef STQ_ALLOC_SNOOP_EN
    logic                     snp_hit;
    logic [CPU_DATA_BITS-1:0] snp_data;

    stq_cdb_match u_alloc_match (
        .cdb_ports (sq.cdb_ports),
        .tag       (sq.stq_entry.src_1_a.tag),
        .hit       (snp_hit),
        .data      (snp_data)
    );

    // Capture a same-cycle broadcast so the dispatch cycle cannot lose a wakeup.
    always_comb begin
        alloc_entry          = sq.stq_entry;
        alloc_entry.is_valid = 1'b1;
        alloc_entry.agu_comp = 1'b0;
        if (sq.stq_entry.src_1_a.is_renamed && snp_hit) begin
            alloc_entry.src_1_a.data       = snp_data;
            alloc_entry.src_1_a.is_renamed = 1'b0;
        end
    end
`else
    // Entry is written as dispatched; dispatch avoids same-cycle broadcasts of pending tags.
    always_comb begin
        alloc_entry          = sq.stq_entry;
        alloc_entry.is_valid = 1'b1;
        alloc_entry.agu_comp = 1'b0;
    end
`endif

    // Handshake decode; flush suppresses alloc and commit, reset suppresses the drain request.
    always_comb begin
        head_e    = entry_q[head_q];
        wr_rdy    = (int'(count_q) < STQ_DEPTH);
        alloc     = sq.stq_we && wr_rdy && !sq.flush;
        do_commit = sq.commit_store && !sq.flush &&
                    entry_q[cmt_ptr_q].is_valid && !meta_q[cmt_ptr_q].committed;
        drain     = !rst && head_e.is_valid && meta_q[head_q].committed &&
                    head_e.agu_comp && !head_e.src_1_a.is_renamed && !sq.cache_stall;
    end

    assign sq.stq_write_rdy = wr_rdy;
    assign sq.mem_req_valid = drain;
    assign sq.mem_req_addr  = head_e.src_0_a.data;
    assign sq.mem_req_data  = head_e.src_1_a.data;
    assign sq.stq_empty     = (count_q == '0);

    // Oldest-first rotation of the registered entries for the load reservation station.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        sq.store_q = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            idx = PTR_W'(wrap_add(32'(head_q), 32'(i), STQ_DEPTH));
            if (entry_q[idx].is_valid) begin
                sq.store_q[i] = entry_q[idx];
            end
        end
    end

    // Head/tail/commit pointers and occupancy; flush rewinds tail to the commit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            cmt_ptr_q <= '0;
            count_q   <= '0;
            cmt_cnt_q <= '0;
        end else begin
            if (drain) begin
                head_q <= ptr_inc(head_q);
            end
            if (sq.flush) begin
                tail_q    <= cmt_ptr_q;
                count_q   <= cmt_cnt_q - CNT_W'(drain);
                cmt_cnt_q <= cmt_cnt_q - CNT_W'(drain);
            end else begin
                if (alloc) begin
                    tail_q <= ptr_inc(tail_q);
                end
                if (do_commit) begin
                    cmt_ptr_q <= ptr_inc(cmt_ptr_q);
                end
                count_q   <= count_q + CNT_W'(alloc) - CNT_W'(drain);
                cmt_cnt_q <= cmt_cnt_q + CNT_W'(do_commit) - CNT_W'(drain);
            end
        end
    end

    // Per-entry state: alloc, drain free, flush squash, AGU address fill, CDB data wakeup, commit mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STQ_DEPTH; i++) begin
                entry_q[i] <= '0;
                meta_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < STQ_DEPTH; i++) begin
                if (alloc && (tail_q == PTR_W'(i))) begin
                    entry_q[i] <= alloc_entry;
                    meta_q[i]  <= '0;
                end else if (drain && (head_q == PTR_W'(i))) begin
                    entry_q[i] <= '0;
                    meta_q[i]  <= '0;
                end else if (sq.flush && !meta_q[i].committed) begin
                    entry_q[i] <= '0;
                end else if (entry_q[i].is_valid) begin
                    if (!entry_q[i].agu_comp && sq.agu_port.is_valid &&
                        (entry_q[i].dest_tag == sq.agu_port.dest_tag)) begin
                        entry_q[i].src_0_a.data <= sq.agu_port.result;
                        entry_q[i].agu_comp     <= 1'b1;
                    end
                    if (entry_q[i].src_1_a.is_renamed && wk_hit[i]) begin
                        entry_q[i].src_1_a.data       <= wk_data[i];
                        entry_q[i].src_1_a.is_renamed <= 1'b0;
                    end
                    if (do_commit && (cmt_ptr_q == PTR_W'(i))) begin
                        meta_q[i].committed <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: reset, full/ignore, fill+drain, stall, flush, wrap, alloc snoop.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next posedge.
// Backpressure: exercises stq_write_rdy deassertion and cache_stall hold.
module tb_store_queue;
    import store_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    store_queue_if #(.STQ_DEPTH(5)) sq_if ();

    store_queue #(.STQ_DEPTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_bus();
        sq_if.stq_we       = 1'b0;
        sq_if.stq_entry    = '0;
        sq_if.agu_port     = '0;
        sq_if.cdb_ports    = '0;
        sq_if.commit_store = 1'b0;
        sq_if.flush        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_bus();
        sq_if.cache_stall = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic instruction_t mk_st(logic [31:0] pc, logic [5:0] tag, logic ren,
                                           logic [5:0] dtag, logic [31:0] dat);
        instruction_t e;
        e                    = '0;
        e.pc                 = pc;
        e.dest_tag           = tag;
        e.src_1_a.is_renamed = ren;
        e.src_1_a.tag        = dtag;
        e.src_1_a.data       = dat;
        return e;
    endfunction

    function automatic writeback_packet_t wb(logic [5:0] tag, logic [31:0] res);
        writeback_packet_t w;
        w.is_valid = 1'b1;
        w.dest_tag = tag;
        w.result   = res;
        return w;
    endfunction

    function automatic int nvalid();
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(sq_if.store_q[i].is_valid);
        return n;
    endfunction

    initial begin
        int q[$];
        bit agud[12];
        bit cmtd[12];
        int nalloc, pend, cyc, cid;
        bit exp_rdy, exp_v, do_al;

        // ---- reset state
        do_reset();
        chk("rst_rdy",   sq_if.stq_write_rdy, 1);
        chk("rst_mreq",  sq_if.mem_req_valid, 0);
        chk("rst_empty", sq_if.stq_empty, 1);
        chk("rst_nval",  nvalid(), 0);
        chk("rst_q0pc",  sq_if.store_q[0].pc, 0);

        // ---- five allocs fill the queue, sixth is ignored
        for (int i = 0; i < 5; i++) begin
            sq_if.stq_entry = mk_st(32'(32'h100 + 4 * i), 6'(i + 1), 1'b1, 6'(10 + i), 32'h0);
            sq_if.stq_we    = 1'b1;
            step();
        end
        chk("full_rdy", sq_if.stq_write_rdy, 0);
        sq_if.stq_entry = mk_st(32'h999, 6'd9, 1'b1, 6'd9, 32'h0);
        step();
        sq_if.stq_we = 1'b0;
        #1;
        chk("full_nval",  nvalid(), 5);
        chk("full_q0pc",  sq_if.store_q[0].pc, 32'h100);
        chk("full_q4pc",  sq_if.store_q[4].pc, 32'h110);
        chk("full_mreq",  sq_if.mem_req_valid, 0);

        // ---- address + data fill, commit, immediate drain
        do_reset();
        sq_if.stq_entry = mk_st(32'h200, 6'd3, 1'b1, 6'd7, 32'h0);
        sq_if.stq_we    = 1'b1;
        step();
        sq_if.stq_we = 1'b0;
        #1;
        chk("fill_ren0",  sq_if.store_q[0].src_1_a.is_renamed, 1);
        chk("fill_mreq0", sq_if.mem_req_valid, 0);
        sq_if.agu_port     = wb(6'd3, 32'h0000_ffff);
        sq_if.cdb_ports[1] = wb(6'd7, 32'hdead_beef);
        sq_if.commit_store = 1'b1;
        step();
        clr_bus();
        #1;
        chk("fill_mreq",  sq_if.mem_req_valid, 1);
        chk("fill_addr",  sq_if.mem_req_addr, 32'h0000_ffff);
        chk("fill_data",  sq_if.mem_req_data, 32'hdead_beef);
        step();
        chk("fill_freed", sq_if.stq_empty, 1);
        chk("fill_mreq1", sq_if.mem_req_valid, 0);

        // ---- cache_stall holds the drain for 3 cycles; two-port hit takes port 0
        do_reset();
        sq_if.cache_stall = 1'b1;
        sq_if.stq_entry   = mk_st(32'h240, 6'd3, 1'b1, 6'd7, 32'h0);
        sq_if.stq_we      = 1'b1;
        step();
        sq_if.stq_we       = 1'b0;
        sq_if.agu_port     = wb(6'd3, 32'h0000_ffff);
        sq_if.cdb_ports[0] = wb(6'd7, 32'h1111_1111);
        sq_if.cdb_ports[1] = wb(6'd7, 32'h2222_2222);
        sq_if.commit_store = 1'b1;
        step();
        clr_bus();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall_c%0d", c), sq_if.mem_req_valid, 0);
            step();
        end
        chk("stall_held", nvalid(), 1);
        sq_if.cache_stall = 1'b0;
        #1;
        chk("stall_mreq", sq_if.mem_req_valid, 1);
        chk("stall_data", sq_if.mem_req_data, 32'h1111_1111);
        step();
        chk("stall_empty", sq_if.stq_empty, 1);

        // ---- alloc 4, commit 2, flush; committed ones drain in order
        do_reset();
        sq_if.cache_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sq_if.stq_entry = mk_st(32'(32'h300 + 4 * i), 6'(20 + i), 1'b0, 6'd0, 32'(32'ha000 + i));
            sq_if.stq_we    = 1'b1;
            step();
        end
        sq_if.stq_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sq_if.agu_port     = wb(6'(20 + i), 32'(32'h8000 + 16 * i));
            sq_if.commit_store = (i < 2);
            step();
        end
        clr_bus();
        sq_if.flush = 1'b1;
        step();
        sq_if.flush = 1'b0;
        #1;
        chk("flush_nval", nvalid(), 2);
        chk("flush_rdy",  sq_if.stq_write_rdy, 1);
        chk("flush_q0",   sq_if.store_q[0].pc, 32'h300);
        chk("flush_q1",   sq_if.store_q[1].pc, 32'h304);
        chk("flush_q2v",  sq_if.store_q[2].is_valid, 0);
        sq_if.stq_entry = mk_st(32'h3f0, 6'd30, 1'b0, 6'd0, 32'h0);
        sq_if.stq_we    = 1'b1;
        step();
        sq_if.stq_we      = 1'b0;
        sq_if.cache_stall = 1'b0;
        #1;
        chk("flush_tail", sq_if.store_q[2].pc, 32'h3f0);
        chk("flush_d0v",  sq_if.mem_req_valid, 1);
        chk("flush_d0a",  sq_if.mem_req_addr, 32'h8000);
        step();
        chk("flush_d1v",  sq_if.mem_req_valid, 1);
        chk("flush_d1a",  sq_if.mem_req_addr, 32'h8010);
        chk("flush_d1d",  sq_if.mem_req_data, 32'ha001);
        step();
        chk("flush_d2v",  sq_if.mem_req_valid, 0);
        chk("flush_left", sq_if.store_q[0].pc, 32'h3f0);
        sq_if.flush = 1'b1;
        step();
        sq_if.flush = 1'b0;
        #1;
        chk("flush_empty", sq_if.stq_empty, 1);

        // ---- 12 stores through depth 5 with a small reference model
        do_reset();
        nalloc = 0;
        pend   = -1;
        cyc    = 0;
        while ((nalloc < 12 || q.size() > 0) && cyc < 200) begin
            sq_if.cache_stall = (cyc >= 2 && cyc < 10);
            sq_if.stq_we      = (nalloc < 12);
            sq_if.stq_entry   = mk_st(32'(32'h400 + 4 * nalloc), 6'(nalloc + 1), 1'b0, 6'd0,
                                      32'(32'hd000 + nalloc));
            sq_if.agu_port    = (pend >= 0) ? wb(6'(pend + 1), 32'(32'h9000 + pend)) : '0;
            cid = -1;
            for (int j = q.size() - 1; j >= 0; j--) if (!cmtd[q[j]]) cid = q[j];
            sq_if.commit_store = (cid >= 0);
            #1;
            exp_rdy = (q.size() < 5);
            exp_v   = (q.size() > 0) && agud[q[0]] && cmtd[q[0]] && !sq_if.cache_stall;
            chk($sformatf("wrap_rdy_c%0d", cyc),  sq_if.stq_write_rdy, exp_rdy);
            chk($sformatf("wrap_mreq_c%0d", cyc), sq_if.mem_req_valid, exp_v);
            chk($sformatf("wrap_nval_c%0d", cyc), nvalid(), q.size());
            if (exp_v) begin
                chk($sformatf("wrap_addr_c%0d", cyc), sq_if.mem_req_addr, 32'(32'h9000 + q[0]));
                chk($sformatf("wrap_data_c%0d", cyc), sq_if.mem_req_data, 32'(32'hd000 + q[0]));
            end
            for (int j = 0; j < q.size(); j++)
                chk($sformatf("wrap_pc_c%0d_%0d", cyc, j), sq_if.store_q[j].pc, 32'(32'h400 + 4 * q[j]));
            do_al = sq_if.stq_we && exp_rdy;
            step();
            if (pend >= 0) agud[pend] = 1'b1;
            if (cid >= 0)  cmtd[cid]  = 1'b1;
            if (exp_v) void'(q.pop_front());
            if (do_al) begin
                q.push_back(nalloc);
                pend = nalloc;
                nalloc++;
            end else begin
                pend = -1;
            end
            cyc++;
        end
        clr_bus();
        sq_if.cache_stall = 1'b0;
        #1;
        chk("wrap_bound", (cyc < 200), 1);
        chk("wrap_empty", sq_if.stq_empty, 1);

        // ---- dispatch-cycle broadcast of the pending data tag
        do_reset();
        sq_if.stq_entry    = mk_st(32'h500, 6'd40, 1'b1, 6'd4, 32'h0);
        sq_if.stq_we       = 1'b1;
        sq_if.cdb_ports[0] = wb(6'd4, 32'h1234);
        step();
        clr_bus();
        #1;
`ifdef STQ_ALLOC_SNOOP_EN
        chk("snoop_ren",  sq_if.store_q[0].src_1_a.is_renamed, 0);
        chk("snoop_data", sq_if.store_q[0].src_1_a.data, 32'h1234);
`else
        chk("nosnoop_ren",  sq_if.store_q[0].src_1_a.is_renamed, 1);
        chk("nosnoop_data", sq_if.store_q[0].src_1_a.data, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
